io_port_peripheral: RTL and testbench
=====================================

// Module: io_port_peripheral
// PURPOSE
//   Device-side partner of the core's I/O ports: feeds IN data, sinks OUT data, drives the interrupt line.
//   Host pushes words into an input FIFO; the core reads the FIFO head on its 16-bit input port.
//   OUT writes from the core are queued in an output FIFO that the host drains.
//   Host interrupt requests become fixed-width interrupt pulses, with a holdoff between pulses and a one-deep pending latch.
// PARAMETERS
//   DW             16  data width of every port word
//   DEPTH           8  entries per FIFO; power of 2, >=2
//   INT_CYCLES      2  cycles cpu_int is held high per interrupt, >=1
//   HOLDOFF_CYCLES  4  cycles cpu_int is held low after a pulse before the next one, >=1
// PORTS
//   clk            in   1   clock
//   rst            in   1   reset, asynchronous, active-high
//   host_in_valid  in   1   host offers host_in_data
//   host_in_ready  out  1   input FIFO can accept a word (= !in_full)
//   host_in_data   in   DW  word for the core's input port
//   host_out_valid out  1   output FIFO not empty
//   host_out_ready in   1   host takes host_out_data this cycle
//   host_out_data  out  DW  output FIFO head
//   host_irq_req   in   1   single-cycle interrupt request
//   host_irq_busy  out  1   interrupt FSM not IDLE or request pending
//   cpu_in_port    out  DW  input FIFO head; last popped word when FIFO is empty
//   cpu_in_rd      in   1   core consumed cpu_in_port (IN executed)
//   cpu_out_port   in   DW  core output port value
//   cpu_out_wr     in   1   core OUT strobe
//   cpu_int        out  1   interrupt line to core (registered)
//   err_clr        in   1   clears all sticky error flags
//   err_flags      out  3   sticky {irq_merged, out_overflow, in_underflow}
// BEHAVIOUR
//   Reset: both FIFOs empty; cpu_in_port=0; host_out_data=0; cpu_int=0.
//     Also at reset: FSM=IDLE, pending=0, err_flags=0, host_in_ready=1, host_out_valid=0, host_irq_busy=0.
//   FIFO mechanics: pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
//     full means MSBs differ and the low bits are equal; empty means the pointers are equal.
//   Push is accepted iff !full, or iff a pop happens in the same cycle.
//   A pop on an empty FIFO is ignored; a push in that same cycle is still accepted.
//   Input path:
//     A host_in_valid&&host_in_ready word appears on cpu_in_port the next cycle if the FIFO was empty.
//     cpu_in_rd pops the head and captures it into the hold register.
//     cpu_in_rd on an empty FIFO sets in_underflow; cpu_in_port keeps the held value.
//   Output path:
//     cpu_out_wr pushes cpu_out_port; host_out_valid rises the next cycle.
//     cpu_out_wr while full with no host pop drops the word and sets out_overflow.
//   Interrupt FSM: IDLE -> ASSERT -> HOLDOFF -> IDLE, counted by a down-counter.
//     IDLE: a host_irq_req moves to ASSERT; cpu_int=1 from the next cycle, for INT_CYCLES cycles.
//     ASSERT -> HOLDOFF: cpu_int=0 for HOLDOFF_CYCLES cycles.
//     HOLDOFF end: if pending, clear it and go to ASSERT; otherwise go to IDLE.
//     A request in ASSERT or HOLDOFF sets pending.
//     A request while pending is already set is merged and sets irq_merged.
//   Errors: a set and err_clr in the same cycle leave the flag set.
//   Reset asserted mid-transfer or mid-pulse: FIFO contents discarded, cpu_int drops immediately.
// CONFIGURATION
//   IO_IRQ_ON_INPUT_EN defined: an input-FIFO empty->non-empty transition generates an internal irq request.
//     It is ORed with host_irq_req and follows the same pending/merge rules.
//   Undefined: interrupts come only from host_irq_req.
// STRUCTURE
//   Package io_port_pkg holds:
//     - DW default, the irq_state_t enum {IDLE, ASSERT, HOLDOFF}
//     - the err_flags bit indices ERR_IN_UNDERFLOW=0, ERR_OUT_OVERFLOW=1, ERR_IRQ_MERGED=2
//   Sub-module io_sync_fifo (DW, DEPTH): push/pop/full/empty/head ports.
//     Instantiated twice, for the input and output paths.
//   This top level holds the hold register, interrupt FSM, counter and error flags.
// TESTING
//   1 Push 0x1111, 0x2222 from host; pulse cpu_in_rd twice.
//     -> cpu_in_port shows 0x1111, then 0x2222; cpu_in_port stays 0x2222 after the FIFO empties.
//   2 cpu_in_rd on an empty FIFO -> err_flags=3'b001, cpu_in_port unchanged; err_clr -> 3'b000.
//   3 Nine cpu_out_wr (0..8) with host_out_ready=0 -> the first 8 words are queued.
//     Word 8 is dropped and err_flags[1]=1; draining returns 0..7 in order.
//   4 Single host_irq_req -> cpu_int high for exactly 2 cycles starting 1 cycle later; host_irq_busy low after 4 holdoff cycles.
//   5 Requests in cycles 0, 1 and 2 -> exactly two pulses separated by 4 low cycles; err_flags[2]=1.
//   6 rst asserted while cpu_int=1 and both FIFOs hold data -> all outputs return to reset values asynchronously.
//     IO_IRQ_ON_INPUT_EN variant: first push into an empty input FIFO -> one pulse.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared types and constants for the I/O port peripheral: data width default,
// interrupt FSM states and err_flags bit positions.
package io_port_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_t;

  localparam int ERR_IN_UNDERFLOW = 0;
  localparam int ERR_OUT_OVERFLOW = 1;
  localparam int ERR_IRQ_MERGED   = 2;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is taken
// only when a pop frees a slot in the same cycle, and a pop on empty is ignored.
module io_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_port_peripheral.sv
// Device-side partner of the core's I/O ports: input FIFO, output FIFO and a
// pulse-shaping interrupt FSM. Define IO_IRQ_ON_INPUT_EN to also interrupt on input arrival.
module io_port_peripheral
  import io_port_pkg::*;
#(
  parameter int DW             = DW_DEFAULT,
  parameter int DEPTH          = 8,
  parameter int INT_CYCLES     = 2,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_in_valid,
  output logic          host_in_ready,
  input  logic [DW-1:0] host_in_data,
  output logic          host_out_valid,
  input  logic          host_out_ready,
  output logic [DW-1:0] host_out_data,
  input  logic          host_irq_req,
  output logic          host_irq_busy,
  output logic [DW-1:0] cpu_in_port,
  input  logic          cpu_in_rd,
  input  logic [DW-1:0] cpu_out_port,
  input  logic          cpu_out_wr,
  output logic          cpu_int,
  input  logic          err_clr,
  output logic [2:0]    err_flags
);

  localparam int CNT_MAX = (INT_CYCLES > HOLDOFF_CYCLES) ? INT_CYCLES : HOLDOFF_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic          in_full, in_empty, in_push;
  logic [DW-1:0] in_head, hold_q;
  logic          out_full, out_empty;
  logic          irq_req, merged;
  logic [2:0]    err_set;
  irq_state_t    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          pend_q, pend_n;

  assign in_push        = host_in_valid && host_in_ready;
  assign host_in_ready  = !in_full;
  assign host_out_valid = !out_empty;
  assign cpu_in_port    = in_empty ? hold_q : in_head;
  assign host_irq_busy  = (state_q != IDLE) || pend_q;

  io_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_push),
    .push_data (host_in_data),
    .pop       (cpu_in_rd),
    .full      (in_full),
    .empty     (in_empty),
    .head      (in_head)
  );

  io_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cpu_out_wr),
    .push_data (cpu_out_port),
    .pop       (host_out_ready),
    .full      (out_full),
    .empty     (out_empty),
    .head      (host_out_data)
  );

`ifdef IO_IRQ_ON_INPUT_EN
  assign irq_req = host_irq_req || (in_empty && in_push);
`else
  assign irq_req = host_irq_req;
`endif

  // The hold register keeps the last word the core consumed for reads on empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (cpu_in_rd && !in_empty) begin
      hold_q <= in_head;
    end
  end

  always_comb begin
    err_set                   = '0;
    err_set[ERR_IN_UNDERFLOW] = cpu_in_rd && in_empty;
    err_set[ERR_OUT_OVERFLOW] = cpu_out_wr && out_full && !host_out_ready;
    err_set[ERR_IRQ_MERGED]   = merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flags <= '0;
    end else begin
      err_flags <= (err_flags & {3{!err_clr}}) | err_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      cpu_int <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pend_q  <= pend_n;
      cpu_int <= (state_n == ASSERT);
    end
  end

  // At the end of holdoff a pending request starts the next pulse at once;
  // a request landing in that same cycle becomes the new pending one.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pend_n  = pend_q;
    merged  = 1'b0;
    case (state_q)
      IDLE: begin
        if (irq_req) begin
          state_n = ASSERT;
          cnt_n   = CW'(INT_CYCLES - 1);
        end
      end
      ASSERT: begin
        if (irq_req) begin
          if (pend_q) merged = 1'b1;
          else        pend_n = 1'b1;
        end
        if (cnt_q == '0) begin
          state_n = HOLDOFF;
          cnt_n   = CW'(HOLDOFF_CYCLES - 1);
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          if (pend_q || irq_req) begin
            state_n = ASSERT;
            cnt_n   = CW'(INT_CYCLES - 1);
            pend_n  = pend_q && irq_req;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
          if (irq_req) begin
            if (pend_q) merged = 1'b1;
            else        pend_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_io_port_peripheral.sv
// Self-checking bench for io_port_peripheral: directed steps plus random traffic
// checked against a queue/time-window reference model.
module tb_io_port_peripheral;

  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int INT_C  = 2;
  localparam int HOLD_C = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_in_valid, host_in_ready;
  logic [DW-1:0] host_in_data;
  logic          host_out_valid, host_out_ready;
  logic [DW-1:0] host_out_data;
  logic          host_irq_req, host_irq_busy;
  logic [DW-1:0] cpu_in_port;
  logic          cpu_in_rd;
  logic [DW-1:0] cpu_out_port;
  logic          cpu_out_wr;
  logic          cpu_int;
  logic          err_clr;
  logic [2:0]    err_flags;

  io_port_peripheral #(
    .DW(DW), .DEPTH(DEPTH), .INT_CYCLES(INT_C), .HOLDOFF_CYCLES(HOLD_C)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_in_data   (host_in_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_out_data  (host_out_data),
    .host_irq_req   (host_irq_req),
    .host_irq_busy  (host_irq_busy),
    .cpu_in_port    (cpu_in_port),
    .cpu_in_rd      (cpu_in_rd),
    .cpu_out_port   (cpu_out_port),
    .cpu_out_wr     (cpu_out_wr),
    .cpu_int        (cpu_int),
    .err_clr        (err_clr),
    .err_flags      (err_flags)
  );

  always #5 clk = ~clk;

  // Reference model: FIFOs as queues, interrupt service as a time window [s_start, e_end].
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] m_hold;
  logic [2:0]    m_err;
  bit            m_pend;
  int            t, s_start, e_end;
  int            assert_count = 0;
  int            fail_count   = 0;

  task automatic modelReset();
    in_q.delete();
    out_q.delete();
    m_hold  = '0;
    m_err   = '0;
    m_pend  = 1'b0;
    t       = 0;
    s_start = -1000;
    e_end   = -1000;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("host_in_ready", 32'(host_in_ready), 32'(in_q.size() < DEPTH));
    chk("cpu_in_port", 32'(cpu_in_port), 32'((in_q.size() > 0) ? in_q[0] : m_hold));
    chk("host_out_valid", 32'(host_out_valid), 32'(out_q.size() > 0));
    if (out_q.size() > 0) chk("host_out_data", 32'(host_out_data), 32'(out_q[0]));
    chk("cpu_int", 32'(cpu_int), 32'((t >= s_start) && (t < s_start + INT_C)));
    chk("host_irq_busy", 32'(host_irq_busy), 32'((t <= e_end) || m_pend));
    chk("err_flags", 32'(err_flags), 32'(m_err));
  endtask

  task automatic modelStep(input bit iv, input logic [DW-1:0] id, input bit ordy,
                           input bit req, input bit rd, input logic [DW-1:0] od,
                           input bit wr, input bit clr);
    bit         was_empty, in_push, ireq, opop, ofull;
    logic [2:0] set;
    set       = '0;
    was_empty = (in_q.size() == 0);
    in_push   = iv && (in_q.size() < DEPTH);
    ireq      = req;
`ifdef IO_IRQ_ON_INPUT_EN
    ireq = req || (was_empty && in_push);
`endif
    if (rd) begin
      if (!was_empty) m_hold = in_q.pop_front();
      else            set[0] = 1'b1;
    end
    if (in_push) in_q.push_back(id);
    opop  = ordy && (out_q.size() > 0);
    ofull = (out_q.size() == DEPTH);
    if (opop) void'(out_q.pop_front());
    if (wr) begin
      if (!ofull || opop) out_q.push_back(od);
      else                set[1] = 1'b1;
    end
    if (t == e_end) begin
      if (m_pend || ireq) begin
        s_start = t + 1;
        e_end   = t + INT_C + HOLD_C;
        m_pend  = m_pend && ireq;
      end
    end else if (t < e_end) begin
      if (ireq) begin
        if (m_pend) set[2] = 1'b1;
        else        m_pend = 1'b1;
      end
    end else if (ireq) begin
      s_start = t + 1;
      e_end   = t + INT_C + HOLD_C;
    end
    m_err = (clr ? 3'b000 : m_err) | set;
  endtask

  // Drive one cycle of inputs, advance the model, then check at the next falling edge.
  task automatic applyStimulus(input bit iv, input logic [DW-1:0] id, input bit ordy,
                               input bit req, input bit rd, input logic [DW-1:0] od,
                               input bit wr, input bit clr);
    host_in_valid  = iv;
    host_in_data   = id;
    host_out_ready = ordy;
    host_irq_req   = req;
    cpu_in_rd      = rd;
    cpu_out_port   = od;
    cpu_out_wr     = wr;
    err_clr        = clr;
    modelStep(iv, id, ordy, req, rd, od, wr, clr);
    @(posedge clk);
    t++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, 0, '0, 0, 0);
  endtask

  int r1, r2, rises, highs;
  bit prev_int;

  initial begin
    rst = 1'b1;
    host_in_valid = 0; host_in_data = '0; host_out_ready = 0; host_irq_req = 0;
    cpu_in_rd = 0; cpu_out_port = '0; cpu_out_wr = 0; err_clr = 0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput();

    // Input path ordering and hold register
    applyStimulus(1, 16'h1111, 0, 0, 0, '0, 0, 0);
    chk("t1_first", 32'(cpu_in_port), 32'h1111);
    applyStimulus(1, 16'h2222, 0, 0, 0, '0, 0, 0);
    applyStimulus(0, '0, 0, 0, 1, '0, 0, 0);
    chk("t1_second", 32'(cpu_in_port), 32'h2222);
    applyStimulus(0, '0, 0, 0, 1, '0, 0, 0);
    chk("t1_held", 32'(cpu_in_port), 32'h2222);

    // Underflow and clear
    applyStimulus(0, '0, 0, 0, 1, '0, 0, 0);
    chk("t2_underflow", 32'(err_flags), 32'h1);
    chk("t2_port_kept", 32'(cpu_in_port), 32'h2222);
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 1);
    chk("t2_cleared", 32'(err_flags), 32'h0);

    // Output overflow then ordered drain
    for (int i = 0; i < 9; i++) applyStimulus(0, '0, 0, 0, 0, 16'(i), 1, 0);
    chk("t3_overflow", 32'(err_flags), 32'h2);
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", 32'(host_out_data), 32'(i));
      applyStimulus(0, '0, 1, 0, 0, '0, 0, 0);
    end
    chk("t3_empty", 32'(host_out_valid), 32'h0);
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 1);
    idle(12);

    // Single interrupt pulse shape
    applyStimulus(0, '0, 0, 1, 0, '0, 0, 0);
    chk("t4_int_c1", 32'(cpu_int), 32'h1);
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 0);
    chk("t4_int_c2", 32'(cpu_int), 32'h1);
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 0);
    chk("t4_int_c3", 32'(cpu_int), 32'h0);
    idle(3);
    chk("t4_busy_c6", 32'(host_irq_busy), 32'h1);
    idle(1);
    chk("t4_busy_c7", 32'(host_irq_busy), 32'h0);
    idle(2);

    // Back-to-back requests: two pulses, one merge
    r1 = -1; r2 = -1; rises = 0; highs = 0; prev_int = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, '0, 0, (i < 3), 0, '0, 0, 0);
      if (cpu_int) highs++;
      if (cpu_int && !prev_int) begin
        rises++;
        if (r1 < 0) r1 = i; else r2 = i;
      end
      prev_int = cpu_int;
    end
    chk("t5_rises", 32'(rises), 32'd2);
    chk("t5_highs", 32'(highs), 32'd4);
    chk("t5_spacing", 32'(r2 - r1), 32'(INT_C + HOLD_C));
    chk("t5_merged", 32'(err_flags[2]), 32'h1);
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 1) == 1), 16'($urandom), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), 16'($urandom),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
    end
    idle(15);

    // Asynchronous reset mid-pulse with both FIFOs loaded
    applyStimulus(1, 16'hABCD, 0, 1, 0, 16'h5A5A, 1, 0);
    chk("t6_pre_int", 32'(cpu_int), 32'h1);
    chk("t6_pre_out", 32'(host_out_valid), 32'h1);
    host_in_valid = 0; host_irq_req = 0; cpu_out_wr = 0;
    #2 rst = 1'b1;
    #1;
    chk("t6_cpu_int", 32'(cpu_int), 32'h0);
    chk("t6_in_ready", 32'(host_in_ready), 32'h1);
    chk("t6_out_valid", 32'(host_out_valid), 32'h0);
    chk("t6_out_data", 32'(host_out_data), 32'h0);
    chk("t6_cpu_in", 32'(cpu_in_port), 32'h0);
    chk("t6_busy", 32'(host_irq_busy), 32'h0);
    chk("t6_err", 32'(err_flags), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput();
    applyStimulus(1, 16'h0F0F, 0, 0, 0, '0, 0, 0);
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
